maxpool2x2_stream: RTL and testbench
====================================

Name: maxpool2x2_stream

Overview:
- Streaming 2x2 stride-2 max-pool stage (S2) for one feature map.
- Sits directly downstream of the C1 convolution output and upstream of C3.
- Consumes a raster-order C1 pixel stream gated by the active-low S2 enable from the layer control unit.
- Emits pooled pixels in raster order with an active-low output strobe that downstream C3 logic samples.

Parameters:
- DATA_W, 16, signed pixel width (two's complement) on input and output.
- IN_W, 28, input row length in pixels; must be even and >= 2.
- IN_H, 28, input rows per frame; must be even and >= 2.
- Derived (localparam): OUT_W = IN_W/2, COL_W = clog2(IN_W), ROW_W = clog2(IN_H).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en_n  in  1  active-low input enable (S2_en); din is accepted on a rising edge when en_n=0.
- din  in  DATA_W  signed C1 pixel, raster order.
- dout  out  DATA_W  signed pooled pixel; registered.
- dout_en_n  out  1  active-low, one-cycle strobe marking dout valid.
- frame_done  out  1  active-high, one-cycle pulse coincident with the last pooled pixel of a frame.
- out_col  out  clog2(OUT_W)  column index of the current dout; registered with dout.

Behaviour:
- Reset (rst=0, asynchronous):
  - col=0, row=0, hold=0.
  - dout=0, dout_en_n=1, frame_done=0, out_col=0.
  - Line buffer contents are not reset; every entry is written on an even row before it is read.
- Storage: hold register (DATA_W), line buffer lb[OUT_W] of DATA_W each, col counter (0..IN_W-1), row counter (0..IN_H-1).
- Accept cycle (en_n=0):
  - col even: hold <= din.
  - col odd: m = signed_max(hold, din).
    - Row even: lb[col>>1] <= m.
    - Row odd: dout <= signed_max(lb[col>>1], m), out_col <= col>>1, dout_en_n <= 0.
  - Counters: col increments. At col=IN_W-1, col wraps to 0 and row increments. At row=IN_H-1 with col=IN_W-1, row wraps to 0.
  - frame_done <= 1 on the accept with row=IN_H-1 and col=IN_W-1, in the same cycle that strobe is produced.
- Any cycle not producing an output: dout_en_n <= 1 and frame_done <= 0. dout and out_col hold their last value.
- Stall (en_n=1): no counter, hold or lb change; outputs hold except that the strobe and frame_done deassert. Gaps of any length are allowed anywhere, including between the two pixels of a horizontal pair.
- Latency: dout_en_n goes low on the clock edge that accepts the 2nd pixel of the 2nd row of a window, so dout is visible in the following cycle.
- Throughput: 1 pixel/cycle in; OUT_W*IN_H/2 outputs per frame (196 at defaults). Outputs occur only on odd rows at odd columns, never back-to-back.
- Comparison rules:
  - Signed; ties return the equal value.
  - No saturation; output width equals input width.
- Back-to-back frames: pixel 0 of the next frame is accepted the cycle after the last pixel of the previous one, with no bubble. Leftover lb data is overwritten on row 0.
- Reset mid-frame: the partial window is discarded and the next accepted pixel is treated as row 0, col 0. No output strobe for the aborted frame.
- X on din while en_n=1 must not propagate to any state.

Test Plan:
- Ramp: 28x28 frame with din = row*28+col, en_n held 0.
  - Exactly 196 strobes.
  - First dout=29 at out_col=0; last dout=783 with frame_done=1.
- Signed data: window {-5,-3,-8,-1}.
  - dout=-1.
  - Window {-32768,-32768,-32768,-32768} gives dout=-32768; tie case gives an equal value.
- Random stalls: same ramp frame with en_n randomly high 40% of cycles, including mid-pair.
  - Output sequence is identical to the no-stall run.
  - dout_en_n never low during a cycle following an en_n=1 cycle.
- Back-to-back frames: two ramp frames, the second offset by +1000, with no gap.
  - 392 strobes total; frame_done pulses exactly twice.
  - First dout of frame 2 = 1029.
- Mid-frame reset: assert rst=0 for 1 cycle after 300 accepted pixels, then send a full ramp frame.
  - No strobe before row 1 of the new frame.
  - First dout=29; 196 strobes total after reset.
- Small geometry: IN_W=4, IN_H=2, din 1..8.
  - Outputs 6, 8 at out_col 0, 1.
  - frame_done with the second output.

Source files
------------

// File: rtl/maxpool2x2_stream_if.sv
// Stream bundle between the C1 pixel source, the S2 max-pool stage and the C3 sink.
// The master modport is the driving/observing side; the pool stage uses slave.
interface maxpool2x2_stream_if #(
    parameter int DATA_W = 16,
    parameter int OCOL_W = 4
);
    logic                     en_n;
    logic signed [DATA_W-1:0] din;
    logic signed [DATA_W-1:0] dout;
    logic                     dout_en_n;
    logic                     frame_done;
    logic [OCOL_W-1:0]        out_col;

    modport master (
        output en_n,
        output din,
        input  dout,
        input  dout_en_n,
        input  frame_done,
        input  out_col
    );

    modport slave (
        input  en_n,
        input  din,
        output dout,
        output dout_en_n,
        output frame_done,
        output out_col
    );
endinterface

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 signed max-pool (S2): horizontal pair max into a half-row
// line buffer on even rows, full window max emitted on odd rows at odd columns.
module maxpool2x2_stream #(
    parameter int DATA_W = 16,
    parameter int IN_W   = 28,
    parameter int IN_H   = 28
) (
    input  logic                clk,
    input  logic                rst,
    maxpool2x2_stream_if.slave  s
);
    localparam int OUT_W  = IN_W / 2;
    localparam int COL_W  = $clog2(IN_W);
    localparam int ROW_W  = $clog2(IN_H);
    localparam int OCOL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    // Geometry must give whole 2x2 windows; catch bad overrides at elaboration.
    generate
        if ((IN_W % 2) != 0 || IN_W < 2 || (IN_H % 2) != 0 || IN_H < 2) begin : g_bad_geometry
            $error("maxpool2x2_stream: IN_W and IN_H must be even and >= 2");
        end
    endgenerate

    function automatic logic signed [DATA_W-1:0] smax(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (a >= b) ? a : b;
    endfunction

    logic [COL_W-1:0]         r_col;
    logic [ROW_W-1:0]         r_row;
    logic signed [DATA_W-1:0] r_hold;
    logic signed [DATA_W-1:0] r_lb [OUT_W];
    logic signed [DATA_W-1:0] r_dout;
    logic                     r_dout_en_n;
    logic                     r_frame_done;
    logic [OCOL_W-1:0]        r_out_col;

    logic                     w_accept;
    logic                     w_col_odd;
    logic                     w_row_odd;
    logic                     w_col_last;
    logic                     w_row_last;
    logic                     w_lb_wr;
    logic                     w_emit;
    logic [OCOL_W-1:0]        w_lb_idx;
    logic signed [DATA_W-1:0] w_pair_max;
    logic signed [DATA_W-1:0] w_win_max;

    // din is only consumed under w_accept, so X while stalled never reaches state.
    assign w_accept   = ~s.en_n;
    assign w_col_odd  = r_col[0];
    assign w_row_odd  = r_row[0];
    assign w_col_last = (r_col == COL_W'(IN_W - 1));
    assign w_row_last = (r_row == ROW_W'(IN_H - 1));
    assign w_lb_idx   = OCOL_W'(r_col >> 1);
    assign w_lb_wr    = w_accept & w_col_odd & ~w_row_odd;
    assign w_emit     = w_accept & w_col_odd &  w_row_odd;
    assign w_pair_max = smax(r_hold, s.din);
    assign w_win_max  = smax(r_lb[w_lb_idx], w_pair_max);

    // Raster position and the left pixel of the current horizontal pair.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col  <= '0;
            r_row  <= '0;
            r_hold <= '0;
        end else if (w_accept) begin
            if (!w_col_odd) begin
                r_hold <= s.din;
            end
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // NOTE: the line buffer has no reset; every entry is rewritten on an even row
    // before any odd row reads it, so resetting it would only cost flops and fanout.
    always_ff @(posedge clk) begin
        if (w_lb_wr) begin
            r_lb[w_lb_idx] <= w_pair_max;
        end
    end

    // Strobe and frame_done default high/low every cycle; data and column hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout       <= '0;
            r_dout_en_n  <= 1'b1;
            r_frame_done <= 1'b0;
            r_out_col    <= '0;
        end else begin
            r_dout_en_n  <= 1'b1;
            r_frame_done <= 1'b0;
            if (w_emit) begin
                r_dout       <= w_win_max;
                r_out_col    <= w_lb_idx;
                r_dout_en_n  <= 1'b0;
                r_frame_done <= w_row_last & w_col_last;
            end
        end
    end

    assign s.dout       = r_dout;
    assign s.dout_en_n  = r_dout_en_n;
    assign s.frame_done = r_frame_done;
    assign s.out_col    = r_out_col;
endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed bench for maxpool2x2_stream: a 28x28 instance for ramp, stall, back-to-back
// and reset scenarios, and a 4x2 instance for signed and small-geometry windows.
module tb_maxpool2x2_stream;
    localparam int DATA_W   = 16;
    localparam int BW       = 28;
    localparam int BH       = 28;
    localparam int B_OUT_W  = BW / 2;
    localparam int B_OCOL_W = $clog2(B_OUT_W);
    localparam int B_NOUT   = B_OUT_W * BH / 2;
    localparam int SW       = 4;
    localparam int SH       = 2;
    localparam int S_OCOL_W = 1;

    typedef struct {
        int d;
        int c;
        bit fd;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    out_t bq[$];
    out_t sq[$];
    int   b_fd_cnt = 0;
    int   b_stall_viol = 0;
    logic b_en_at_edge = 1'b1;

    maxpool2x2_stream_if #(.DATA_W(DATA_W), .OCOL_W(B_OCOL_W)) big_if ();
    maxpool2x2_stream_if #(.DATA_W(DATA_W), .OCOL_W(S_OCOL_W)) sml_if ();

    maxpool2x2_stream #(.DATA_W(DATA_W), .IN_W(BW), .IN_H(BH)) u_big (
        .clk (clk),
        .rst (rst),
        .s   (big_if)
    );

    maxpool2x2_stream #(.DATA_W(DATA_W), .IN_W(SW), .IN_H(SH)) u_sml (
        .clk (clk),
        .rst (rst),
        .s   (sml_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) b_en_at_edge = big_if.en_n;

    always @(negedge clk) begin
        if (big_if.frame_done === 1'b1) b_fd_cnt++;
        if (big_if.dout_en_n === 1'b0) begin
            bq.push_back('{int'(big_if.dout), int'(big_if.out_col), big_if.frame_done});
            if (b_en_at_edge !== 1'b0) b_stall_viol++;
        end
        if (sml_if.dout_en_n === 1'b0)
            sq.push_back('{int'(sml_if.dout), int'(sml_if.out_col), sml_if.frame_done});
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic b_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            big_if.en_n = 1'b1;
            big_if.din  = 'x;
        end
    endtask

    task automatic b_push(input int d);
        @(negedge clk);
        big_if.en_n = 1'b0;
        big_if.din  = DATA_W'(d);
    endtask

    // Ramp frame din = offset + row*BW + col; stall_pct is the chance of idle cycles before a pixel.
    task automatic b_ramp(input int offset, input int n_pix, input int stall_pct);
        for (int p = 0; p < n_pix; p++) begin
            while (int'($urandom_range(0, 99)) < stall_pct) b_idle(1);
            b_push(offset + p);
        end
    endtask

    task automatic b_check_seq(input string tag, input int base, input int offset);
        for (int k = 0; k < B_NOUT; k++) begin
            int r = k / B_OUT_W;
            int c = k % B_OUT_W;
            check({tag, "_dout"}, bq[base + k].d, offset + (2 * r + 1) * BW + 2 * c + 1);
            check({tag, "_col"}, bq[base + k].c, c);
        end
    endtask

    task automatic s_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sml_if.en_n = 1'b1;
            sml_if.din  = 'x;
        end
    endtask

    task automatic s_frame(input int px[8], input bit stall_mid_pair);
        for (int i = 0; i < 8; i++) begin
            if (stall_mid_pair && (i % 2 == 1)) s_idle(2);
            @(negedge clk);
            sml_if.en_n = 1'b0;
            sml_if.din  = DATA_W'(px[i]);
        end
        s_idle(3);
    endtask

    task automatic s_expect(input string tag, input int d0, input int d1);
        check({tag, "_count"}, sq.size(), 2);
        if (sq.size() == 2) begin
            check({tag, "_dout0"}, sq[0].d, d0);
            check({tag, "_col0"}, sq[0].c, 0);
            check({tag, "_fd0"}, int'(sq[0].fd), 0);
            check({tag, "_dout1"}, sq[1].d, d1);
            check({tag, "_col1"}, sq[1].c, 1);
            check({tag, "_fd1"}, int'(sq[1].fd), 1);
        end
        sq.delete();
    endtask

    initial begin
        big_if.en_n = 1'b1;
        big_if.din  = 'x;
        sml_if.en_n = 1'b1;
        sml_if.din  = 'x;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_dout", int'(big_if.dout), 0);
        check("rst_dout_en_n", int'(big_if.dout_en_n), 1);
        check("rst_frame_done", int'(big_if.frame_done), 0);
        check("rst_out_col", int'(big_if.out_col), 0);
        rst = 1'b1;
        b_idle(2);

        // Ramp frame, no stalls
        bq.delete();
        b_fd_cnt = 0;
        b_ramp(0, BW * BH, 0);
        b_idle(3);
        check("ramp_count", bq.size(), B_NOUT);
        check("ramp_fd_count", b_fd_cnt, 1);
        if (bq.size() == B_NOUT) begin
            check("ramp_first", bq[0].d, 29);
            check("ramp_last", bq[B_NOUT-1].d, 783);
            check("ramp_last_fd", int'(bq[B_NOUT-1].fd), 1);
            b_check_seq("ramp", 0, 0);
        end

        // Ramp frame with random stalls, including mid-pair
        bq.delete();
        b_fd_cnt = 0;
        b_stall_viol = 0;
        b_ramp(0, BW * BH, 40);
        b_idle(3);
        check("stall_count", bq.size(), B_NOUT);
        check("stall_fd_count", b_fd_cnt, 1);
        check("stall_strobe_after_idle", b_stall_viol, 0);
        if (bq.size() == B_NOUT) b_check_seq("stall", 0, 0);

        // Back-to-back frames, second offset by +1000
        bq.delete();
        b_fd_cnt = 0;
        b_ramp(0, BW * BH, 0);
        b_ramp(1000, BW * BH, 0);
        b_idle(3);
        check("b2b_count", bq.size(), 2 * B_NOUT);
        check("b2b_fd_count", b_fd_cnt, 2);
        if (bq.size() == 2 * B_NOUT) begin
            check("b2b_f2_first", bq[B_NOUT].d, 1029);
            check("b2b_f2_last", bq[2*B_NOUT-1].d, 1783);
            check("b2b_f1_last_fd", int'(bq[B_NOUT-1].fd), 1);
            b_check_seq("b2b_f2", B_NOUT, 1000);
        end

        // Mid-frame reset after 300 accepted pixels
        b_ramp(5000, 300, 0);
        @(negedge clk);
        big_if.en_n = 1'b1;
        big_if.din  = 'x;
        rst = 1'b0;
        #1;
        check("mid_rst_dout_en_n", int'(big_if.dout_en_n), 1);
        check("mid_rst_out_col", int'(big_if.out_col), 0);
        check("mid_rst_dout", int'(big_if.dout), 0);
        @(negedge clk);
        rst = 1'b1;
        bq.delete();
        b_fd_cnt = 0;
        b_ramp(0, BW, 0);
        b_idle(2);
        check("mid_rst_row0_quiet", bq.size(), 0);
        b_ramp(BW, BW * (BH - 1), 0);
        b_idle(3);
        check("mid_rst_count", bq.size(), B_NOUT);
        check("mid_rst_fd_count", b_fd_cnt, 1);
        if (bq.size() == B_NOUT) begin
            check("mid_rst_first", bq[0].d, 29);
            check("mid_rst_first_col", bq[0].c, 0);
        end

        // Small 4x2 geometry: plain, signed/extreme, ties with a mid-pair stall
        sq.delete();
        s_frame('{1, 2, 3, 4, 5, 6, 7, 8}, 1'b0);
        s_expect("small", 6, 8);
        s_frame('{-5, -3, -32768, -32768, -8, -1, -32768, -32768}, 1'b0);
        s_expect("signed", -1, -32768);
        s_frame('{3, -2, 100, 100, 3, 3, 100, -100}, 1'b1);
        s_expect("tie", 3, 100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, observed %0d/%0d checks", n_pass, n_chk);
        $fatal(1, "timeout");
    end
endmodule
